// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 set-2 receiver that tracks up to two held keys for the paddle logic
module ps2_keycode_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT = 5000
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode1,
  output logic [7:0] keycode2,
  output logic [7:0] code_byte,
  output logic       code_valid,
  output logic       frame_err
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;
  logic [1:0] clk_s, dat_s, filt;
  logic [CW-1:0] fcnt [2];
  logic clk_q, fall, timeout, accept, bad, brk, ext, par;
  logic [7:0] shreg;
  logic [2:0] bitcnt;
  logic [WW-1:0] wd;
  always_ff @(posedge vga_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      filt <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
      clk_q <= 1'b1;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      clk_q <= filt[1];
      for (int i = 0; i < 2; i++) begin
        if ((i == 1 ? clk_s[1] : dat_s[1]) == filt[i]) fcnt[i] <= '0;
        else if (fcnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i] <= ~filt[i];
          fcnt[i] <= '0;
        end else fcnt[i] <= fcnt[i] + 1'b1;
      end
    end
  assign fall = clk_q & ~filt[1];
  // the abort lands TIMEOUT cycles after the last sample event
  assign timeout = state != IDLE && !fall && wd == WW'(TIMEOUT - 2);
  assign accept = fall && state == STOP && filt[0] && (^shreg ^ par);
  assign bad = timeout || (fall && state == STOP && !accept);
  always_comb begin
    state_nx = state;
    if (timeout) state_nx = IDLE;
    else if (fall)
      case (state)
        IDLE:    state_nx = filt[0] ? IDLE : DATA;
        DATA:    state_nx = bitcnt == 3'd7 ? PARITY : DATA;
        PARITY:  state_nx = STOP;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge vga_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      wd <= '0;
      bitcnt <= '0;
      shreg <= '0;
      par <= 1'b0;
    end else begin
      state <= state_nx;
      wd <= (fall || state == IDLE) ? '0 : wd + 1'b1;
      if (fall && state == IDLE) bitcnt <= '0;
      if (fall && state == DATA) begin
        shreg <= {filt[0], shreg[7:1]};
        bitcnt <= bitcnt + 1'b1;
      end
      if (fall && state == PARITY) par <= filt[0];
    end
  always_ff @(posedge vga_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      keycode1 <= '0;
      keycode2 <= '0;
      code_byte <= '0;
      code_valid <= 1'b0;
      frame_err <= 1'b0;
      brk <= 1'b0;
      ext <= 1'b0;
    end else begin
      code_valid <= accept;
      frame_err <= bad;
      if (accept) code_byte <= shreg;
      if (bad) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (accept) begin
        if (shreg == 8'hE0) ext <= 1'b1;
        else if (shreg == 8'hF0) brk <= 1'b1;
        else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (shreg != 8'h00 && shreg != 8'hFF && !ext) begin
            if (brk) begin
              if (keycode1 == shreg) keycode1 <= '0;
              if (keycode2 == shreg) keycode2 <= '0;
            end else if (keycode1 != shreg && keycode2 != shreg) begin
              if (keycode1 == 8'h00) keycode1 <= shreg;
              else if (keycode2 == 8'h00) keycode2 <= shreg;
            end
          end
        end
      end
    end
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb_ps2_keycode_rx: directed PS/2 frames with a queue of expected code bytes
module tb_ps2_keycode_rx;
  localparam int FL = 4;
  localparam int TO = 200;
  localparam int LAT = 2 + FL;
  logic vga_clk = 1'b0, sys_rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] keycode1, keycode2, code_byte, exp_b;
  logic code_valid, frame_err;
  int vecs = 0, miss = 0, cyc_cnt = 0, fall_cyc = 0, valid_cyc = 0, err_cyc = 0, err_exp = 0;
  logic [7:0] q [$];
  ps2_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode1(keycode1), .keycode2(keycode2), .code_byte(code_byte),
    .code_valid(code_valid), .frame_err(frame_err)
  );
  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc_cnt++;
  always @(negedge vga_clk)
    if (sys_rst_n) begin
      if (code_valid) begin
        valid_cyc = cyc_cnt;
        vecs++;
        assert (q.size() > 0) else begin
          miss++;
          $error("FAIL code_valid_unexpected: got %h required no pulse", code_byte);
        end
        if (q.size() > 0) begin
          exp_b = q.pop_front();
          vecs++;
          assert (code_byte === exp_b) else begin
            miss++;
            $error("FAIL code_byte: got %h required %h", code_byte, exp_b);
          end
        end
      end
      if (frame_err) begin
        err_cyc = cyc_cnt;
        vecs++;
        assert (err_exp > 0) else begin
          miss++;
          $error("FAIL frame_err_unexpected: got 1 required 0");
        end
        if (err_exp > 0) err_exp--;
      end
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] req);
    vecs++;
    assert (got === req) else begin
      miss++;
      $error("FAIL %s: got %0h required %0h", tag, got, req);
    end
  endtask
  task automatic slots(input string tag, input logic [7:0] k1, input logic [7:0] k2);
    chk({tag, "_kc1"}, 32'(keycode1), 32'(k1));
    chk({tag, "_kc2"}, 32'(keycode2), 32'(k2));
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask
  task automatic send_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      cyc(3);
      ps2_clk = 1'b0;
      cyc(2);
      ps2_clk = 1'b1;
      cyc(5);
    end else cyc(10);
    ps2_clk = 1'b0;
    fall_cyc = cyc_cnt;
    cyc(20);
    ps2_clk = 1'b1;
    cyc(10);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int glitch_bit);
    logic [10:0] bits;
    bits = {1'b1, ~^b ^ bad_par, b, 1'b0};
    if (bad_par) err_exp++;
    else q.push_back(b);
    for (int i = 0; i < 11; i++) send_bit(bits[i], i == glitch_bit);
    ps2_data = 1'b1;
    cyc(20);
  endtask
  task automatic send_partial(input logic [7:0] b, input int n);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < n; i++) send_bit(b[i], 1'b0);
    ps2_data = 1'b1;
  endtask
  initial begin
    cyc(3);
    chk("rst_kc1", 32'(keycode1), 0);
    chk("rst_kc2", 32'(keycode2), 0);
    chk("rst_code_byte", 32'(code_byte), 0);
    chk("rst_code_valid", 32'(code_valid), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    sys_rst_n = 1'b1;
    cyc(10);
    send_frame(8'h1D, 1'b0, -1);
    chk("accept_latency", 32'(valid_cyc - fall_cyc), 32'(LAT + 1));
    slots("make_1d", 8'h1D, 8'h00);
    send_frame(8'h44, 1'b0, -1);
    slots("make_44", 8'h1D, 8'h44);
    repeat (3) send_frame(8'h44, 1'b0, -1);
    slots("repeat_44", 8'h1D, 8'h44);
    send_frame(8'h1B, 1'b0, -1);
    slots("full_drop", 8'h1D, 8'h44);
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'h1D, 1'b0, -1);
    slots("break_1d", 8'h00, 8'h44);
    send_frame(8'h4B, 1'b0, -1);
    slots("refill_kc1", 8'h4B, 8'h44);
    send_frame(8'h1D, 1'b1, -1);
    chk("parity_err_seen", 32'(err_exp), 0);
    slots("parity_err", 8'h4B, 8'h44);
    err_exp++;
    send_partial(8'h55, 4);
    cyc(TO + 30);
    chk("timeout_err_seen", 32'(err_exp), 0);
    chk("timeout_latency", 32'(err_cyc - fall_cyc), 32'(LAT + TO));
    send_frame(8'h1D, 1'b0, -1);
    slots("after_timeout", 8'h4B, 8'h44);
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'h4B, 1'b0, -1);
    slots("break_4b", 8'h00, 8'h44);
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'h75, 1'b0, -1);
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'h75, 1'b0, -1);
    slots("extended", 8'h00, 8'h44);
    send_frame(8'h1D, 1'b0, -1);
    slots("flags_clear", 8'h1D, 8'h44);
    send_frame(8'h1B, 1'b0, 3);
    chk("glitch_byte", 32'(code_byte), 32'h1B);
    slots("glitch", 8'h1D, 8'h44);
    send_partial(8'hAA, 4);
    @(posedge vga_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_kc1", 32'(keycode1), 0);
    chk("async_rst_kc2", 32'(keycode2), 0);
    chk("async_rst_code_byte", 32'(code_byte), 0);
    chk("async_rst_code_valid", 32'(code_valid), 0);
    chk("async_rst_frame_err", 32'(frame_err), 0);
    cyc(5);
    sys_rst_n = 1'b1;
    cyc(10);
    send_frame(8'h44, 1'b0, -1);
    slots("post_reset", 8'h44, 8'h00);
    cyc(20);
    chk("queue_drained", 32'(q.size()), 0);
    chk("errors_drained", 32'(err_exp), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
